// File: rtl/kernel_window_sequencer_pkg.sv
// Shared types and elaboration-time helpers for the kernel window sequencer.
package kernel_seq_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } seq_state_e;

  // Number of window positions along one axis.
  function automatic int unsigned out_dim(input int unsigned img,
                                          input int unsigned k,
                                          input int unsigned stride);
    return (img - k) / stride + 1;
  endfunction

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/kernel_window_sequencer_if.sv
// Control/status bundle between the convolution datapath and the sequencer.
interface kernel_window_sequencer_if
  import kernel_seq_pkg::*;
#(
  parameter int unsigned IMG_W  = 4,
  parameter int unsigned IMG_H  = 4,
  parameter int unsigned K      = 3,
  parameter int unsigned STRIDE = 1
);
  localparam int unsigned OUT_W = out_dim(IMG_W, K, STRIDE);
  localparam int unsigned OUT_H = out_dim(IMG_H, K, STRIDE);
  localparam int unsigned TAP_W = clog2_min1(K * K);
  localparam int unsigned K_W   = clog2_min1(K);
  localparam int unsigned OR_W  = clog2_min1(OUT_H);
  localparam int unsigned OC_W  = clog2_min1(OUT_W);
  localparam int unsigned PR_W  = clog2_min1(IMG_H);
  localparam int unsigned PC_W  = clog2_min1(IMG_W);

  logic             start;
  logic             adv;
  logic             clear;
  logic             busy;
  logic             valid;
  logic [TAP_W-1:0] tap_idx;
  logic [K_W-1:0]   kr;
  logic [K_W-1:0]   kc;
  logic [OR_W-1:0]  out_r;
  logic [OC_W-1:0]  out_c;
  logic [PR_W-1:0]  pix_r;
  logic [PC_W-1:0]  pix_c;
  logic             first;
  logic             last;
  logic             done;

  modport master (
    output start, adv, clear,
    input  busy, valid, tap_idx, kr, kc, out_r, out_c, pix_r, pix_c, first, last, done
  );

  modport slave (
    input  start, adv, clear,
    output busy, valid, tap_idx, kr, kc, out_r, out_c, pix_r, pix_c, first, last, done
  );
endinterface

// File: rtl/kernel_window_sequencer_mod_counter.sv
// Modulo-MOD counter; wrap flags the enabled step from MOD-1 back to 0 so
// instances can be chained as a mixed-radix counter.
module mod_counter
  import kernel_seq_pkg::*;
#(
  parameter int unsigned MOD   = 3,
  parameter int unsigned WIDTH = clog2_min1(MOD)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = enable & (count == WIDTH'(MOD - 1));

  // Count register: synchronous clear wins over enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/kernel_window_sequencer.sv
// Convolution scan sequencer: walks kernel taps (KC fastest) inside each
// output window (OC, then OR) and reports tap/window/pixel coordinates.
module kernel_window_sequencer
  import kernel_seq_pkg::*;
#(
  parameter int unsigned IMG_W      = 4,
  parameter int unsigned IMG_H      = 4,
  parameter int unsigned K          = 3,
  parameter int unsigned STRIDE     = 1,
  parameter bit          CONTINUOUS = 1'b0
) (
  input logic                      clk,
  input logic                      reset_n,
  kernel_window_sequencer_if.slave bus
);

  localparam int unsigned OUT_W = out_dim(IMG_W, K, STRIDE);
  localparam int unsigned OUT_H = out_dim(IMG_H, K, STRIDE);
  localparam int unsigned TAP_W = clog2_min1(K * K);
  localparam int unsigned K_W   = clog2_min1(K);
  localparam int unsigned OR_W  = clog2_min1(OUT_H);
  localparam int unsigned OC_W  = clog2_min1(OUT_W);
  localparam int unsigned PR_W  = clog2_min1(IMG_H);
  localparam int unsigned PC_W  = clog2_min1(IMG_W);

  seq_state_e      state_q;
  seq_state_e      state_d;
  logic            run;
  logic            step;
  logic            kc_wrap;
  logic            kr_wrap;
  logic            oc_wrap;
  logic            frame_end;
  logic            done_q;
  logic [K_W-1:0]  kc;
  logic [K_W-1:0]  kr;
  logic [OC_W-1:0] out_c;
  logic [OR_W-1:0] out_r;

  assign run  = (state_q == RUN);
  assign step = run & bus.adv & ~bus.clear;

  // Indices only move in RUN, and the full carry chain returns them to zero
  // on the final tap, so IDLE needs no separate zeroing beyond CLEAR.
  mod_counter #(.MOD(K)) u_kc (
    .clk(clk), .reset_n(reset_n), .clear(bus.clear),
    .enable(step), .count(kc), .wrap(kc_wrap)
  );

  mod_counter #(.MOD(K)) u_kr (
    .clk(clk), .reset_n(reset_n), .clear(bus.clear),
    .enable(kc_wrap), .count(kr), .wrap(kr_wrap)
  );

  mod_counter #(.MOD(OUT_W)) u_oc (
    .clk(clk), .reset_n(reset_n), .clear(bus.clear),
    .enable(kr_wrap), .count(out_c), .wrap(oc_wrap)
  );

  mod_counter #(.MOD(OUT_H)) u_or (
    .clk(clk), .reset_n(reset_n), .clear(bus.clear),
    .enable(oc_wrap), .count(out_r), .wrap(frame_end)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: START from IDLE, frame end leaves RUN unless continuous, CLEAR dominates.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN:  if (frame_end && !CONTINUOUS) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.clear) state_d = IDLE;
  end

  // Frame-complete pulse, one cycle after the final tap is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= frame_end;
    end
  end

  assign bus.busy    = run;
  assign bus.valid   = run;
  assign bus.done    = done_q;
  assign bus.kr      = kr;
  assign bus.kc      = kc;
  assign bus.out_r   = out_r;
  assign bus.out_c   = out_c;
  assign bus.tap_idx = TAP_W'(32'(kr) * K + 32'(kc));
  assign bus.pix_r   = PR_W'(32'(out_r) * STRIDE + 32'(kr));
  assign bus.pix_c   = PC_W'(32'(out_c) * STRIDE + 32'(kc));
  assign bus.first   = run & (kr == '0) & (kc == '0);
  assign bus.last    = run & (kr == K_W'(K - 1)) & (kc == K_W'(K - 1));

endmodule
